// File: rtl/guvm_inst_feeder.sv
// rtl/guvm_inst_feeder.sv - instruction FIFO and icache-output responder with configurable wait states
module guvm_inst_feeder #(
    parameter int          DEPTH     = 8,
    parameter int          LATENCY   = 1,
    parameter int          EMPTY_NOP = 1,
    parameter logic [31:0] NOP_WORD  = 32'h01000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    input  logic [31:0]                push_inst,
    output logic                       push_ready,
    input  logic                       flush,
    input  logic                       fetch_req,
    input  logic [31:0]                fetch_addr,
    output logic [31:0]                ic_data,
    output logic                       ic_hold,
    output logic                       ic_mds,
    output logic                       ic_exception,
    output logic [$clog2(DEPTH):0]     level,
    output logic [31:0]                inst_count,
    output logic                       seq_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_STALL} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [31:0]   ic_data_q, inst_count_q, last_addr_q;
    logic          ic_mds_q, seq_err_q, armed_q;

    logic          empty, full, pop, push_acc, deliver, bypass, latch, seq_bad;
    logic [31:0]   deliver_data;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pop          = 1'b0;
        deliver      = 1'b0;
        bypass       = 1'b0;
        deliver_data = mem[rd_ptr_q[AW-1:0]];
        case (state_q)
            S_IDLE: begin
                if (fetch_req) begin
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP: begin
                if (!empty) begin
                    pop     = 1'b1;
                    deliver = 1'b1;
                    state_d = S_IDLE;
                end else if (EMPTY_NOP != 0) begin
                    deliver      = 1'b1;
                    deliver_data = NOP_WORD;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                // The waiting word goes straight out; it never occupies a FIFO slot.
                if (push_valid) begin
                    bypass       = 1'b1;
                    deliver      = 1'b1;
                    deliver_data = push_inst;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            pop     = 1'b0;
            deliver = 1'b0;
            bypass  = 1'b0;
        end
    end

    // A pop on the same edge frees a slot, so a push into a full FIFO is taken then.
    assign push_acc = push_valid && (!full || pop) && !bypass && !flush;
    assign latch    = (state_q == S_IDLE) && fetch_req && !flush;
    assign seq_bad  = latch && armed_q && (fetch_addr != last_addr_q + 32'd4);

    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr_q[AW-1:0]] <= push_inst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ic_data_q    <= 32'd0;
            ic_mds_q     <= 1'b0;
            inst_count_q <= 32'd0;
            seq_err_q    <= 1'b0;
            armed_q      <= 1'b0;
            last_addr_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ic_mds_q <= deliver;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                armed_q  <= 1'b0;
            end else begin
                if (push_acc) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
                if (pop)      rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
                if (deliver)  armed_q  <= 1'b1;
            end
            if (latch)   last_addr_q <= fetch_addr;
            if (seq_bad) seq_err_q   <= 1'b1;
            if (deliver) begin
                ic_data_q    <= deliver_data;
                inst_count_q <= inst_count_q + 32'd1;
            end
        end
    end

    assign push_ready   = !full;
    assign level        = wr_ptr_q - rd_ptr_q;
    assign ic_data      = ic_data_q;
    assign ic_mds       = ic_mds_q;
    assign ic_exception = 1'b0;
    assign inst_count   = inst_count_q;
    assign seq_err      = seq_err_q;
    assign ic_hold      = !((state_q == S_WAIT) || (state_q == S_STALL) ||
                            ((state_q == S_RESP) && empty && (EMPTY_NOP == 0)));
endmodule

// File: tb/tb_guvm_inst_feeder.sv
// tb/tb_guvm_inst_feeder.sv - directed-vector bench for guvm_inst_feeder
module tb_guvm_inst_feeder;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic [31:0] push_inst, fetch_addr;
    logic        a_push_valid, a_fetch_req, b_push_valid, b_fetch_req;
    logic        a_ready, a_hold, a_mds, a_exc, a_serr;
    logic        b_ready, b_hold, b_mds, b_exc, b_serr;
    logic [31:0] a_data, a_cnt, b_data, b_cnt;
    logic [3:0]  a_level, b_level;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    guvm_inst_feeder #(.DEPTH(8), .LATENCY(2), .EMPTY_NOP(1), .NOP_WORD(32'h01000000)) u_dut_a (
        .clk(clk), .rst(rst), .push_valid(a_push_valid), .push_inst(push_inst), .push_ready(a_ready),
        .flush(flush), .fetch_req(a_fetch_req), .fetch_addr(fetch_addr), .ic_data(a_data),
        .ic_hold(a_hold), .ic_mds(a_mds), .ic_exception(a_exc), .level(a_level),
        .inst_count(a_cnt), .seq_err(a_serr));

    guvm_inst_feeder #(.DEPTH(8), .LATENCY(1), .EMPTY_NOP(0), .NOP_WORD(32'h01000000)) u_dut_b (
        .clk(clk), .rst(rst), .push_valid(b_push_valid), .push_inst(push_inst), .push_ready(b_ready),
        .flush(flush), .fetch_req(b_fetch_req), .fetch_addr(fetch_addr), .ic_data(b_data),
        .ic_hold(b_hold), .ic_mds(b_mds), .ic_exception(b_exc), .level(b_level),
        .inst_count(b_cnt), .seq_err(b_serr));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_a(input logic [31:0] addr, output int lat, output int hold_lo,
                           output logic [31:0] data);
        fetch_addr  = addr;
        a_fetch_req = 1'b1;
        tick();
        a_fetch_req = 1'b0;
        lat = 0;
        hold_lo = 0;
        while (!a_mds && lat < 20) begin
            if (!a_hold) hold_lo++;
            tick();
            lat++;
        end
        data = a_data;
    endtask

    task automatic check_reset_a(input string p);
        check({p, "_data"},  a_data, 32'd0);
        check({p, "_hold"},  {31'd0, a_hold}, 32'd1);
        check({p, "_mds"},   {31'd0, a_mds}, 32'd0);
        check({p, "_exc"},   {31'd0, a_exc}, 32'd0);
        check({p, "_ready"}, {31'd0, a_ready}, 32'd1);
        check({p, "_level"}, {28'd0, a_level}, 32'd0);
        check({p, "_count"}, a_cnt, 32'd0);
        check({p, "_seqerr"}, {31'd0, a_serr}, 32'd0);
    endtask

    initial begin
        int          lat, hlo, exp_cnt, quiet;
        logic [31:0] d;
        rst = 1'b1; flush = 1'b0; push_inst = '0; fetch_addr = '0;
        a_push_valid = 1'b0; a_fetch_req = 1'b0; b_push_valid = 1'b0; b_fetch_req = 1'b0;
        exp_cnt = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_a("rst");
        quiet = 1;
        repeat (4) begin
            tick();
            if (a_mds || !a_hold) quiet = 0;
        end
        check("idle_quiet", quiet, 1);

        a_push_valid = 1'b1; push_inst = 32'h8E00C002; tick();
        push_inst = 32'h82102001; tick();
        a_push_valid = 1'b0;
        check("lat2_level", {28'd0, a_level}, 32'd2);
        fetch_a(32'h0, lat, hlo, d);
        check("lat2_f0_lat", lat, 3);
        check("lat2_f0_hold", hlo, 2);
        check("lat2_f0_data", d, 32'h8E00C002);
        fetch_a(32'h4, lat, hlo, d);
        check("lat2_f1_lat", lat, 3);
        check("lat2_f1_hold", hlo, 2);
        check("lat2_f1_data", d, 32'h82102001);
        exp_cnt = 2;
        check("lat2_count", a_cnt, exp_cnt);
        check("lat2_seqerr", {31'd0, a_serr}, 32'd0);

        fetch_a(32'h8, lat, hlo, d);
        exp_cnt++;
        check("nop_data", d, 32'h01000000);
        check("nop_lat", lat, 3);
        check("nop_count", a_cnt, exp_cnt);

        flush = 1'b1; tick(); flush = 1'b0;
        fetch_a(32'h0, lat, hlo, d); exp_cnt++;
        check("seq_first", {31'd0, a_serr}, 32'd0);
        fetch_a(32'hC, lat, hlo, d); exp_cnt++;
        check("seq_jump", {31'd0, a_serr}, 32'd1);
        fetch_a(32'h10, lat, hlo, d); exp_cnt++;
        check("seq_sticky", {31'd0, a_serr}, 32'd1);

        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 9; i++) begin
            a_push_valid = 1'b1;
            push_inst = 32'hC0DE0000 + 32'(i);
            tick();
            check($sformatf("full_ready%0d", i), {31'd0, a_ready}, (i < 7) ? 32'd1 : 32'd0);
        end
        a_push_valid = 1'b0;
        check("full_level", {28'd0, a_level}, 32'd8);
        fetch_addr = 32'h200; a_fetch_req = 1'b1; tick(); a_fetch_req = 1'b0;
        tick(); tick();
        a_push_valid = 1'b1; push_inst = 32'hFEEDF00D; tick(); a_push_valid = 1'b0;
        exp_cnt++;
        check("pp_mds", {31'd0, a_mds}, 32'd1);
        check("pp_data", a_data, 32'hC0DE0000);
        check("pp_level", {28'd0, a_level}, 32'd8);
        fetch_a(32'h204, lat, hlo, d); exp_cnt++;
        check("pp_next_data", d, 32'hC0DE0001);
        check("pp_next_level", {28'd0, a_level}, 32'd7);
        check("pp_count", a_cnt, exp_cnt);

        fetch_addr = 32'h208; a_fetch_req = 1'b1; tick(); a_fetch_req = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        quiet = 1;
        repeat (6) begin
            if (a_mds) quiet = 0;
            tick();
        end
        check("flush_no_mds", quiet, 1);
        check("flush_level", {28'd0, a_level}, 32'd0);
        check("flush_hold", {31'd0, a_hold}, 32'd1);
        check("flush_count", a_cnt, exp_cnt);

        fetch_addr = 32'h0; b_fetch_req = 1'b1; tick(); b_fetch_req = 1'b0;
        quiet = 1;
        repeat (5) begin
            if (b_hold || b_mds) quiet = 0;
            tick();
        end
        check("stall_hold_low", quiet, 1);
        b_push_valid = 1'b1; push_inst = 32'hA0102005; tick(); b_push_valid = 1'b0;
        check("stall_mds", {31'd0, b_mds}, 32'd1);
        check("stall_data", b_data, 32'hA0102005);
        check("stall_level", {28'd0, b_level}, 32'd0);
        tick();
        check("stall_mds_pulse", {31'd0, b_mds}, 32'd0);
        check("stall_count", b_cnt, 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        fetch_addr = 32'h100; b_fetch_req = 1'b1; tick(); b_fetch_req = 1'b0;
        tick(); tick();
        b_push_valid = 1'b1; push_inst = 32'h12345678; tick(); b_push_valid = 1'b0;
        check("rearm_data", b_data, 32'h12345678);
        check("rearm_seqerr", {31'd0, b_serr}, 32'd0);

        fetch_addr = 32'h20C; a_fetch_req = 1'b1; tick(); a_fetch_req = 1'b0;
        rst = 1'b1; #1;
        check("arst_hold", {31'd0, a_hold}, 32'd1);
        check("arst_count", a_cnt, 32'd0);
        tick(); tick();
        rst = 1'b0;
        quiet = 1;
        repeat (6) begin
            if (a_mds) quiet = 0;
            tick();
        end
        check("arst_no_mds", quiet, 1);
        check_reset_a("arst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
